// File: rtl/sonic_vc_pkg.sv
// sonic_vc_pkg
// Shared definitions for the RX virtual-channel packet arbiter: default
// widths, the arbiter state encoding and a packed beat record.
package sonic_vc_pkg;

   localparam int DEF_DATA_W  = 128;
   localparam int DEF_EMPTY_W = 2;
   localparam int DEF_CNT_W   = 32;

   // IDLE: between packets; LOCKn: channel n owns the output until its EOP.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [DEF_DATA_W-1:0]  data;
      logic                   sop;
      logic                   eop;
      logic [DEF_EMPTY_W-1:0] empty;
   } beat_t;

endpackage

// File: rtl/sonic_vc_rr_arb2.sv
// sonic_vc_rr_arb2
// Two-requester round-robin picker. A lone request wins outright; when both
// request, the channel that did not win last time is chosen. Purely
// combinational so the grant can drive ready in the same cycle.
module sonic_vc_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   // One-hot grant from the request pair and the previous winner
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/sonic_vc_rx_pkt_arbiter.sv
// sonic_vc_rx_pkt_arbiter
// Merges two upstream packet streams into one channelised stream for the RX
// FIFO adapter. A winning channel keeps the output from SOP to EOP, packets
// alternate round-robin, and the output passes through one register stage.
// Non-SOP beats arriving between packets are drained and flagged.
module sonic_vc_rx_pkt_arbiter
   import sonic_vc_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int EMPTY_W = DEF_EMPTY_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               ch0_valid,
   output logic               ch0_ready,
   input  logic [DATA_W-1:0]  ch0_data,
   input  logic               ch0_sop,
   input  logic               ch0_eop,
   input  logic [EMPTY_W-1:0] ch0_empty,
   input  logic               ch1_valid,
   output logic               ch1_ready,
   input  logic [DATA_W-1:0]  ch1_data,
   input  logic               ch1_sop,
   input  logic               ch1_eop,
   input  logic [EMPTY_W-1:0] ch1_empty,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_channel,
   output logic               out_sop,
   output logic               out_eop,
   output logic [EMPTY_W-1:0] out_empty,
   input  logic               err_clr,
   output logic [1:0]         err_orphan,
   output logic               err_sop,
   output logic [CNT_W-1:0]   pkt_cnt0,
   output logic [CNT_W-1:0]   pkt_cnt1
);

   arb_state_e         state;
   arb_state_e         state_nxt;
   logic               last_grant;
   logic               last_grant_nxt;
   logic               load_en;
   logic [1:0]         valid_v;
   logic [1:0]         sop_v;
   logic [1:0]         req;
   logic [1:0]         gnt;
   logic [1:0]         ready_v;
   logic [1:0]         orphan_set;
   logic [1:0]         cnt_inc;
   logic               lock_ch;
   logic               fwd_ch;
   logic               fwd_vld;
   logic               sop_err_set;
   logic [DATA_W-1:0]  fwd_data;
   logic               fwd_sop;
   logic               fwd_eop;
   logic [EMPTY_W-1:0] fwd_empty;

   logic               vld_p1;
   logic [DATA_W-1:0]  data_p1;
   logic               ch_p1;
   logic               sop_p1;
   logic               eop_p1;
   logic [EMPTY_W-1:0] empty_p1;

   assign valid_v = {ch1_valid, ch0_valid};
   assign sop_v   = {ch1_sop, ch0_sop};

   // The output slot can take a beat when it is empty or being drained now.
   assign load_en = ~vld_p1 | out_ready;

   // Only packet starts compete for the output, and only between packets.
   assign req = (state == IDLE) ? (valid_v & sop_v) : 2'b00;

   sonic_vc_rr_arb2 u_rr_arb (
      .req        (req),
      .last_grant (last_grant),
      .gnt        (gnt)
   );

   // The channel whose beat would be forwarded this cycle: the locked owner,
   // or the fresh round-robin winner while idle.
   assign lock_ch = (state == LOCK1);
   assign fwd_ch  = (state == IDLE) ? gnt[1] : lock_ch;

   assign fwd_data  = fwd_ch ? ch1_data  : ch0_data;
   assign fwd_sop   = fwd_ch ? ch1_sop   : ch0_sop;
   assign fwd_eop   = fwd_ch ? ch1_eop   : ch0_eop;
   assign fwd_empty = fwd_ch ? ch1_empty : ch0_empty;

   // Next state, upstream handshake and per-cycle event strobes
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      ready_v        = 2'b00;
      orphan_set     = 2'b00;
      fwd_vld        = 1'b0;
      sop_err_set    = 1'b0;
      cnt_inc        = 2'b00;
      case (state)
         IDLE: begin
            // Orphan beats are swallowed immediately so a stray
            // continuation cannot block the channel's next packet.
            for (int i = 0; i < 2; i++) begin
               if (gnt[i]) begin
                  ready_v[i] = load_en;
               end else if (valid_v[i] && !sop_v[i]) begin
                  ready_v[i]    = 1'b1;
                  orphan_set[i] = 1'b1;
               end
            end
            fwd_vld = (gnt != 2'b00) && load_en;
            if (fwd_vld) begin
               if (fwd_eop) begin
                  last_grant_nxt = fwd_ch;
                  cnt_inc        = fwd_ch ? 2'b10 : 2'b01;
               end else begin
                  state_nxt = fwd_ch ? LOCK1 : LOCK0;
               end
            end
         end
         LOCK0, LOCK1: begin
            ready_v = lock_ch ? {load_en, 1'b0} : {1'b0, load_en};
            fwd_vld = valid_v[lock_ch] && load_en;
            if (fwd_vld) begin
               // A nested SOP is still forwarded; it is only flagged.
               sop_err_set = fwd_sop;
               if (fwd_eop) begin
                  state_nxt      = IDLE;
                  last_grant_nxt = lock_ch;
                  cnt_inc        = lock_ch ? 2'b10 : 2'b01;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign ch0_ready = ready_v[0];
   assign ch1_ready = ready_v[1];

   // FSM state register; last_grant starts at 1 so ch0 wins the first tie
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // ---- stage p1: registered output beat ----
   // Output register: load when the slot is free, otherwise hold everything
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1   <= 1'b0;
         data_p1  <= '0;
         ch_p1    <= 1'b0;
         sop_p1   <= 1'b0;
         eop_p1   <= 1'b0;
         empty_p1 <= '0;
      end else if (load_en) begin
         vld_p1 <= fwd_vld;
         if (fwd_vld) begin
            data_p1  <= fwd_data;
            ch_p1    <= fwd_ch;
            sop_p1   <= fwd_sop;
            eop_p1   <= fwd_eop;
            empty_p1 <= fwd_empty;
         end
      end
   end

   assign out_valid   = vld_p1;
   assign out_data    = data_p1;
   assign out_channel = ch_p1;
   assign out_sop     = sop_p1;
   assign out_eop     = eop_p1;
   assign out_empty   = empty_p1;

   // Forwarded-packet counters, bumped when a packet's EOP is accepted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         if (cnt_inc[0]) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
         if (cnt_inc[1]) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      end
   end

   // Sticky protocol errors; a new error in the clearing cycle survives
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_orphan <= 2'b00;
         err_sop    <= 1'b0;
      end else begin
         err_orphan <= orphan_set | (err_orphan & ~{2{err_clr}});
         err_sop    <= sop_err_set | (err_sop & ~err_clr);
      end
   end

endmodule

// File: tb/tb_sonic_vc_rx_pkt_arbiter.sv
// tb_sonic_vc_rx_pkt_arbiter
// Directed scenarios followed by a randomized run. Upstream sources hold each
// beat until it is accepted; a packet-level reference model predicts ready,
// output beats, counters and error flags every cycle.
module tb_sonic_vc_rx_pkt_arbiter;
   import sonic_vc_pkg::*;

   localparam int DW = 128;
   localparam int EW = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          ch0_valid, ch0_ready, ch0_sop, ch0_eop;
   logic [DW-1:0] ch0_data;
   logic [EW-1:0] ch0_empty;
   logic          ch1_valid, ch1_ready, ch1_sop, ch1_eop;
   logic [DW-1:0] ch1_data;
   logic [EW-1:0] ch1_empty;
   logic          out_ready, out_valid, out_channel, out_sop, out_eop;
   logic [DW-1:0] out_data;
   logic [EW-1:0] out_empty;
   logic          err_clr, err_sop;
   logic [1:0]    err_orphan;
   logic [CW-1:0] pkt_cnt0, pkt_cnt1;

   sonic_vc_rx_pkt_arbiter #(.DATA_W(DW), .EMPTY_W(EW), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .ch0_valid(ch0_valid), .ch0_ready(ch0_ready), .ch0_data(ch0_data),
      .ch0_sop(ch0_sop), .ch0_eop(ch0_eop), .ch0_empty(ch0_empty),
      .ch1_valid(ch1_valid), .ch1_ready(ch1_ready), .ch1_data(ch1_data),
      .ch1_sop(ch1_sop), .ch1_eop(ch1_eop), .ch1_empty(ch1_empty),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_channel(out_channel), .out_sop(out_sop), .out_eop(out_eop),
      .out_empty(out_empty), .err_clr(err_clr), .err_orphan(err_orphan),
      .err_sop(err_sop), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rate = 100;

   // upstream sources
   beat_t q0[$];
   beat_t q1[$];
   bit    v0, v1;

   // downstream log
   bit            dlv_ch[$];
   logic [DW-1:0] dlv_data[$];
   int            dlv_cyc[$];

   // reference model state: owner -1 means between packets
   int            m_owner, n_owner;
   bit            m_last, n_last;
   bit            m_vld, n_vld;
   beat_t         m_beat, n_beat;
   bit            m_ch, n_ch;
   logic [CW-1:0] m_cnt[2];
   logic [CW-1:0] n_cnt[2];
   logic [1:0]    m_orph, n_orph;
   bit            m_serr, n_serr;
   bit   [1:0]    e_rdy;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_last = 1'b1; m_vld = 1'b0; m_beat = '0; m_ch = 1'b0;
      m_cnt[0] = '0; m_cnt[1] = '0; m_orph = 2'b00; m_serr = 1'b0;
   endtask

   // Apply the arbitration rules to the inputs currently presented.
   task automatic model_eval();
      bit    load, acc;
      int    pick;
      bit    vin[2];
      bit    sin[2];
      beat_t b[2];
      logic [1:0] set_orph;
      bit    set_sop;
      vin[0] = ch0_valid; vin[1] = ch1_valid;
      sin[0] = ch0_sop;   sin[1] = ch1_sop;
      b[0] = '{data: ch0_data, sop: ch0_sop, eop: ch0_eop, empty: ch0_empty};
      b[1] = '{data: ch1_data, sop: ch1_sop, eop: ch1_eop, empty: ch1_empty};
      load = !m_vld || out_ready;
      e_rdy = 2'b00; set_orph = 2'b00; set_sop = 1'b0; pick = -1;
      n_owner = m_owner; n_last = m_last; n_vld = m_vld; n_beat = m_beat; n_ch = m_ch;
      n_cnt[0] = m_cnt[0]; n_cnt[1] = m_cnt[1];
      if (m_owner < 0) begin
         if (vin[0] && sin[0] && vin[1] && sin[1]) pick = m_last ? 0 : 1;
         else if (vin[0] && sin[0]) pick = 0;
         else if (vin[1] && sin[1]) pick = 1;
         for (int i = 0; i < 2; i++) begin
            if (i == pick) e_rdy[i] = load;
            else if (vin[i] && !sin[i]) begin
               e_rdy[i] = 1'b1;
               set_orph[i] = 1'b1;
            end
         end
      end else begin
         pick = m_owner;
         e_rdy[m_owner] = load;
      end
      acc = (pick >= 0) && vin[pick] && e_rdy[pick];
      if (load) begin
         n_vld = acc;
         if (acc) begin n_beat = b[pick]; n_ch = pick[0]; end
      end
      if (acc) begin
         if (m_owner >= 0 && b[pick].sop) set_sop = 1'b1;
         if (b[pick].eop) begin
            n_owner = -1; n_last = pick[0]; n_cnt[pick] = m_cnt[pick] + 1'b1;
         end else begin
            n_owner = pick;
         end
      end
      n_orph = set_orph | (m_orph & ~{2{err_clr}});
      n_serr = set_sop | (m_serr & ~err_clr);
   endtask

   task automatic model_commit();
      m_owner = n_owner; m_last = n_last; m_vld = n_vld; m_beat = n_beat; m_ch = n_ch;
      m_cnt[0] = n_cnt[0]; m_cnt[1] = n_cnt[1]; m_orph = n_orph; m_serr = n_serr;
   endtask

   task automatic drive();
      if (!v0 && q0.size() > 0 && $urandom_range(0, 99) < rate) v0 = 1'b1;
      if (!v1 && q1.size() > 0 && $urandom_range(0, 99) < rate) v1 = 1'b1;
      ch0_valid = v0;
      if (q0.size() > 0) {ch0_data, ch0_sop, ch0_eop, ch0_empty} = q0[0];
      else {ch0_data, ch0_sop, ch0_eop, ch0_empty} = '0;
      ch1_valid = v1;
      if (q1.size() > 0) {ch1_data, ch1_sop, ch1_eop, ch1_empty} = q1[0];
      else {ch1_data, ch1_sop, ch1_eop, ch1_empty} = '0;
   endtask

   // One clock: compare at the falling edge, advance model and sources after
   // the rising edge.
   task automatic cycle();
      bit a0, a1;
      @(negedge clk);
      model_eval();
      check("ch0_ready", ch0_ready, e_rdy[0]);
      check("ch1_ready", ch1_ready, e_rdy[1]);
      check("out_valid", out_valid, m_vld);
      if (m_vld) begin
         check("out_data", out_data, m_beat.data);
         check("out_sop", out_sop, m_beat.sop);
         check("out_eop", out_eop, m_beat.eop);
         check("out_empty", out_empty, m_beat.empty);
         check("out_channel", out_channel, m_ch);
      end
      check("pkt_cnt0", pkt_cnt0, m_cnt[0]);
      check("pkt_cnt1", pkt_cnt1, m_cnt[1]);
      check("err_orphan", err_orphan, m_orph);
      check("err_sop", err_sop, m_serr);
      if (out_valid && out_ready) begin
         dlv_ch.push_back(out_channel);
         dlv_data.push_back(out_data);
         dlv_cyc.push_back(cyc);
      end
      a0 = ch0_valid && ch0_ready;
      a1 = ch1_valid && ch1_ready;
      @(posedge clk);
      #1;
      model_commit();
      cyc++;
      if (a0) begin void'(q0.pop_front()); v0 = 1'b0; end
      if (a1) begin void'(q1.pop_front()); v1 = 1'b0; end
      drive();
   endtask

   task automatic clear_log();
      dlv_ch.delete(); dlv_data.delete(); dlv_cyc.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      q0.delete(); q1.delete(); v0 = 1'b0; v1 = 1'b0;
      out_ready = 1'b1; err_clr = 1'b0; rate = 100;
      drive();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      clear_log();
   endtask

   task automatic push_pkt(input int ch, input int len, input bit bad_sop);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data  = {$urandom, $urandom, $urandom, $urandom};
         b.sop   = (k == 0) || (bad_sop && k == 1 && len >= 3);
         b.eop   = (k == len - 1);
         b.empty = b.eop ? 2'($urandom) : 2'b00;
         if (ch == 0) q0.push_back(b); else q1.push_back(b);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] exp_d[$];
      logic [DW-1:0] held;
      int n;

      // ---- reset state ----
      do_reset();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_sop", out_sop, 1'b0);
      check("rst_out_eop", out_eop, 1'b0);
      check("rst_out_empty", out_empty, '0);
      check("rst_out_channel", out_channel, 1'b0);
      check("rst_err_orphan", err_orphan, 2'b00);
      check("rst_err_sop", err_sop, 1'b0);
      check("rst_pkt_cnt0", pkt_cnt0, '0);
      check("rst_pkt_cnt1", pkt_cnt1, '0);

      // ---- 1: simultaneous SOPs, ch0 first, ch1 follows without a gap ----
      push_pkt(0, 3, 1'b0);
      push_pkt(1, 3, 1'b0);
      drive();
      repeat (8) cycle();
      check("t1_beats", dlv_ch.size(), 6);
      for (int k = 0; k < 6 && k < dlv_ch.size(); k++)
         check("t1_chan_order", dlv_ch[k], (k < 3) ? 1'b0 : 1'b1);
      if (dlv_cyc.size() == 6) check("t1_no_gap", dlv_cyc[5] - dlv_cyc[0], 5);
      check("t1_cnt0", pkt_cnt0, 1);
      check("t1_cnt1", pkt_cnt1, 1);

      // ---- 2: back-to-back packets alternate channels at full rate ----
      do_reset();
      for (int p = 0; p < 4; p++) begin push_pkt(0, 3, 1'b0); push_pkt(1, 3, 1'b0); end
      drive();
      repeat (28) cycle();
      check("t2_beats", dlv_ch.size(), 24);
      for (int k = 0; k < 24 && k < dlv_ch.size(); k++)
         check("t2_alternate", dlv_ch[k], ((k / 3) % 2) != 0);
      if (dlv_cyc.size() == 24) check("t2_full_rate", dlv_cyc[23] - dlv_cyc[0], 23);
      check("t2_cnt0", pkt_cnt0, 4);
      check("t2_cnt1", pkt_cnt1, 4);

      // ---- 3: downstream stall mid-packet on ch1 ----
      do_reset();
      push_pkt(1, 4, 1'b0);
      exp_d.delete();
      foreach (q1[k]) exp_d.push_back(q1[k].data);
      drive();
      repeat (2) cycle();
      held = out_data;
      check("t3_held_is_beat1", held, exp_d[1]);
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         cycle();
         check("t3_stall_valid", out_valid, 1'b1);
         check("t3_stall_data", out_data, held);
      end
      out_ready = 1'b1;
      repeat (6) cycle();
      check("t3_beats", dlv_data.size(), 4);
      for (int k = 0; k < 4 && k < dlv_data.size(); k++)
         check("t3_order", dlv_data[k], exp_d[k]);

      // ---- 4: orphan beat while idle, then clear ----
      do_reset();
      q1.push_back('{data: 128'hDEAD, sop: 1'b0, eop: 1'b0, empty: 2'b00});
      drive();
      cycle();
      check("t4_not_forwarded", out_valid, 1'b0);
      check("t4_err_orphan", err_orphan, 2'b10);
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      check("t4_cleared", err_orphan, 2'b00);
      check("t4_no_output", dlv_data.size(), 0);

      // ---- 5: single-beat packets every cycle, counter wraps ----
      do_reset();
      for (int p = 0; p < 20; p++) push_pkt(0, 1, 1'b0);
      drive();
      repeat (22) cycle();
      check("t5_beats", dlv_data.size(), 20);
      if (dlv_cyc.size() == 20) check("t5_full_rate", dlv_cyc[19] - dlv_cyc[0], 19);
      check("t5_cnt0_wrapped", pkt_cnt0, 20 % 16);

      // ---- 6: reset during beat 2 of a 4-beat ch0 packet ----
      do_reset();
      push_pkt(0, 4, 1'b0);
      push_pkt(0, 2, 1'b0);
      exp_d.delete();
      exp_d.push_back(q0[4].data);
      exp_d.push_back(q0[5].data);
      drive();
      repeat (2) cycle();
      check("t6_pre_valid", out_valid, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_async_clear", out_valid, 1'b0);
      check("t6_async_sop", out_sop, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      clear_log();
      repeat (6) cycle();
      check("t6_err_orphan", err_orphan, 2'b01);
      check("t6_cnt0", pkt_cnt0, 1);
      check("t6_beats", dlv_data.size(), 2);
      for (int k = 0; k < 2 && k < dlv_data.size(); k++)
         check("t6_next_pkt", dlv_data[k], exp_d[k]);

      // ---- randomized traffic with stalls, orphans and nested SOPs ----
      do_reset();
      for (int p = 0; p < 30; p++) begin
         for (int c = 0; c < 2; c++) begin
            if ($urandom_range(0, 99) < 10) begin
               if (c == 0) q0.push_back('{data: {4{$urandom}}, sop: 1'b0, eop: 1'b0, empty: 2'b00});
               else        q1.push_back('{data: {4{$urandom}}, sop: 1'b0, eop: 1'b0, empty: 2'b00});
            end
            push_pkt(c, $urandom_range(1, 4), $urandom_range(0, 99) < 5);
         end
      end
      rate = 60;
      drive();
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < 3000) begin
         out_ready = ($urandom_range(0, 99) < 75);
         err_clr   = ($urandom_range(0, 99) < 5);
         cycle();
         n++;
      end
      check("rnd_drained", q0.size() + q1.size(), 0);
      out_ready = 1'b1;
      err_clr = 1'b0;
      repeat (4) cycle();
      check("rnd_flushed", out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sonic_vc_rx_pkt_arbiter.md
Name: sonic_vc_rx_pkt_arbiter

Overview:
Packet-aware two-channel arbiter that merges two upstream Avalon-ST 128-bit packet streams into the single channelised stream feeding the RX FIFO input adapter. Once a channel wins, its grant is held from SOP to EOP. Arbitration between packets is round-robin. The output is registered through one pipeline stage. Per-channel forwarded-packet counters and sticky protocol-error flags are exposed for CSR readout.

Parameters:
DATA_W, 128, beat width
EMPTY_W, 2, empty-symbol field width
CNT_W, 32, packet counter width

Ports:
clk  in  1  single clock
reset_n  in  1  asynchronous active-low reset
ch0_valid / ch1_valid  in  1  upstream beat valid
ch0_ready / ch1_ready  out  1  upstream beat accepted when valid & ready
ch0_data / ch1_data  in  DATA_W  beat payload
ch0_sop / ch1_sop  in  1  start of packet
ch0_eop / ch1_eop  in  1  end of packet
ch0_empty / ch1_empty  in  EMPTY_W  empty symbols on EOP beat
out_ready  in  1  from FIFO adapter in_ready
out_valid  out  1  registered beat valid
out_data  out  DATA_W  registered payload
out_channel  out  1  source channel of beat
out_sop / out_eop  out  1  packet delimiters
out_empty  out  EMPTY_W  empty field
err_clr  in  1  pulse, clears sticky errors
err_orphan  out  2  sticky: non-SOP beat seen while idle, per channel
err_sop  out  1  sticky: SOP seen inside a locked packet
pkt_cnt0 / pkt_cnt1  out  CNT_W  forwarded packets per channel

Behaviour:
- Reset (async assert, sync release): out_valid/sop/eop 0; out_data, out_empty, out_channel 0; err flags 0; counters 0; state IDLE; last_grant=1, so ch0 has first priority.
- Output stage: load_en = ~out_valid | out_ready. On a load, out_* takes the accepted beat and out_valid=1. If there is no accepted beat and out_ready=1, out_valid goes to 0. While out_valid & ~out_ready, all out_* hold.
- Latency is 1 cycle from upstream accept to out_valid. Throughput is 1 beat/cycle, with no bubble between packets.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE: req[i]=chi_valid & chi_sop. One request: grant it. Two requests: grant ~last_grant. The granted channel gets ready=load_en in the same cycle (combinational grant).
  - Accepted SOP without EOP -> LOCKi.
  - Accepted SOP&EOP (single-beat packet) -> stay IDLE, last_grant=i, pkt_cnti++.
- IDLE orphan handling: a channel with valid & ~sop that is not granted gets ready=1 regardless of load_en. The beat is discarded, err_orphan[i] is set, and the beat is not counted.
- LOCKi: chi_ready=load_en; the other channel's ready=0 (no orphan draining while locked).
  - Accepted beat with EOP -> IDLE, last_grant=i, pkt_cnti++.
  - Accepted beat with SOP (no EOP) -> forwarded unchanged, err_sop set, stays LOCKi.
- out_channel=i for every beat forwarded from chi.
- Counters wrap modulo 2^CNT_W.
- err_clr clears all sticky flags. A set condition in the same cycle wins over the clear.
- Reset mid-packet: the output clears immediately and the downstream packet is truncated with no EOP (the FIFO adapter is reset on the same net). Upstream continuation beats arriving after release are orphans.
- No combinational path from chX_valid to out_*. ch_ready depends combinationally on out_ready, valid and state.

Decomposition:
- Package sonic_vc_pkg: DATA_W/EMPTY_W defaults, the state enum {IDLE, LOCK0, LOCK1}, and a beat struct {data, sop, eop, empty}.
- One sub-module, sonic_vc_rr_arb2: 2-request round-robin, inputs req[1:0] and last_grant, output one-hot gnt. Purely combinational.
- The last_grant register stays in the parent.

Test Plan:
1. After reset, ch0 and ch1 both present SOP of a 3-beat packet in the same cycle, out_ready=1 -> ch0 granted. out_channel=0 beats appear on cycles 1-3, ch1_ready=0 until ch0's EOP is accepted, then the ch1 beats follow with no idle cycle. pkt_cnt0=1, pkt_cnt1=1.
2. Continuous 3-beat packets offered on both channels, 4 packets each -> output channels alternate 0,1,0,1… at 24 beats in 24 cycles. Final pkt_cnt0=4, pkt_cnt1=4.
3. Mid-packet on ch1, out_ready=0 for 3 cycles -> out_valid stays 1, out_data held, ch1_ready=0. After release the remaining beats are delivered in order with no loss or duplication.
4. While IDLE, ch1 presents valid, sop=0, data=0xDEAD -> ch1_ready=1 and the beat is not forwarded (out_valid stays 0). err_orphan=2'b10. An err_clr pulse returns it to 0.
5. ch0 presents single-beat SOP&EOP packets every cycle, ch1 idle -> one output beat per cycle, state never leaves IDLE, pkt_cnt0 increments every cycle.
6. reset_n is asserted low during beat 2 of a 4-beat ch0 packet -> out_valid=0 asynchronously. After release, ch0 beats 3-4 (no SOP) are drained as orphans with err_orphan[0]=1, and the next SOP is forwarded normally.
